// File: rtl/compute_plain_broadcast.sv
// +----------------------------------------------------------------------------+
// | compute_plain_broadcast: alpha = eps*Q(r) + a, beta = S(r) + b per lane,   |
// | sequenced over external evaluate/mul32/add32 units. Option: CPB_INPUT_LATCH_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module compute_plain_broadcast #(
   parameter string FIELD         = "GF256",
   parameter string PARAMETER_SET = "L1",
   parameter string FILE_MEM_INIT = "Y_L1.mem",
   localparam int   c_M  = (PARAMETER_SET == "L5") ? 480 : (PARAMETER_SET == "L3") ? 352 : 230,
   localparam int   c_T  = (PARAMETER_SET == "L5") ? 4 : 3,
   localparam int   c_AW = $clog2(c_M),
   localparam int   c_W  = 32 * c_T
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   output logic            o_done,
   input  logic [7:0]      i_q,
   output logic [c_AW-1:0] o_q_addr,
   output logic            o_q_rd,
   input  logic [7:0]      i_s,
   output logic [c_AW-1:0] o_s_addr,
   output logic            o_s_rd,
   input  logic [c_W-1:0]  i_a,
   input  logic [c_W-1:0]  i_b,
   input  logic [c_W-1:0]  i_r,
   input  logic [c_W-1:0]  i_eps,
   output logic [c_W-1:0]  o_alpha,
   output logic [c_W-1:0]  o_beta,
   output logic            o_start_evaluate,
   output logic [7:0]      o_q_s,
   input  logic [c_AW-1:0] i_q_s_addr,
   input  logic            i_q_s_rd,
   output logic [c_W-1:0]  o_r_eps,
   input  logic [c_W-1:0]  i_evaluate_out,
   input  logic            i_done_evaluate,
   output logic            o_start_mul32,
   output logic [31:0]     o_x_mul32,
   output logic [31:0]     o_y_mul32,
   input  logic [31:0]     i_o_mul32,
   input  logic            i_done_mul32,
   output logic            o_start_add32,
   output logic [c_W-1:0]  o_in_1_add32,
   output logic [c_W-1:0]  o_in_2_add32,
   input  logic [c_W-1:0]  i_add_out_add32,
   input  logic            i_done_add32
);

   localparam logic [1:0] c_LAST = 2'(c_T - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EVAL_Q = 3'd1,
      S_MUL    = 3'd2,
      S_ADD_A  = 3'd3,
      S_EVAL_S = 3'd4,
      S_ADD_B  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   if (!(FIELD == "GF256" || FIELD == "P251")) begin : g_bad_field
      $error("compute_plain_broadcast: unsupported FIELD");
   end
   if (FILE_MEM_INIT == "") begin : g_bad_mem_init
      $error("compute_plain_broadcast: empty FILE_MEM_INIT");
   end

   state_t          state_q;
   logic            start_eval_q;
   logic            start_mul_q;
   logic            start_add_q;
   logic            done_q;
   logic [1:0]      idx_q;
   logic [c_W-1:0]  qr_q;
   logic [c_W-1:0]  sr_q;
   logic [31:0]     prod_q [c_T];
   logic [c_W-1:0]  alpha_q;
   logic [c_W-1:0]  beta_q;

   logic [c_W-1:0]  w_r;
   logic [c_W-1:0]  w_eps;
   logic [c_W-1:0]  w_a;
   logic [c_W-1:0]  w_b;
   logic [c_W-1:0]  w_prod;
   logic [31:0]     w_eps_lane [c_T];
   logic [31:0]     w_qr_lane  [c_T];

`ifdef CPB_INPUT_LATCH_EN
   logic [c_W-1:0]  r_in_q;
   logic [c_W-1:0]  eps_in_q;
   logic [c_W-1:0]  a_in_q;
   logic [c_W-1:0]  b_in_q;

   // Snapshot operands only on a start that the FSM actually accepts.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_in_q   <= '0;
         eps_in_q <= '0;
         a_in_q   <= '0;
         b_in_q   <= '0;
      end else if (state_q == S_IDLE && i_start) begin
         r_in_q   <= i_r;
         eps_in_q <= i_eps;
         a_in_q   <= i_a;
         b_in_q   <= i_b;
      end
   end

   assign w_r   = r_in_q;
   assign w_eps = eps_in_q;
   assign w_a   = a_in_q;
   assign w_b   = b_in_q;
`else
   assign w_r   = i_r;
   assign w_eps = i_eps;
   assign w_a   = i_a;
   assign w_b   = i_b;
`endif

   for (genvar g = 0; g < c_T; g++) begin : g_lane
      assign w_prod[32*g +: 32] = prod_q[g];
      assign w_eps_lane[g]      = w_eps[32*g +: 32];
      assign w_qr_lane[g]       = qr_q[32*g +: 32];
   end

   // A done seen while our own start is still high is stale and ignored.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         start_eval_q <= 1'b0;
         start_mul_q  <= 1'b0;
         start_add_q  <= 1'b0;
         done_q       <= 1'b0;
         idx_q        <= 2'd0;
         qr_q         <= '0;
         sr_q         <= '0;
         alpha_q      <= '0;
         beta_q       <= '0;
         for (int k = 0; k < c_T; k++) prod_q[k] <= '0;
      end else begin
         start_eval_q <= 1'b0;
         start_mul_q  <= 1'b0;
         start_add_q  <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  state_q      <= S_EVAL_Q;
                  start_eval_q <= 1'b1;
               end
            end
            S_EVAL_Q: begin
               if (i_done_evaluate && !start_eval_q) begin
                  qr_q        <= i_evaluate_out;
                  idx_q       <= 2'd0;
                  start_mul_q <= 1'b1;
                  state_q     <= S_MUL;
               end
            end
            S_MUL: begin
               if (i_done_mul32 && !start_mul_q) begin
                  prod_q[idx_q] <= i_o_mul32;
                  if (idx_q == c_LAST) begin
                     start_add_q <= 1'b1;
                     state_q     <= S_ADD_A;
                  end else begin
                     idx_q       <= idx_q + 2'd1;
                     start_mul_q <= 1'b1;
                  end
               end
            end
            S_ADD_A: begin
               if (i_done_add32 && !start_add_q) begin
                  alpha_q      <= i_add_out_add32;
                  start_eval_q <= 1'b1;
                  state_q      <= S_EVAL_S;
               end
            end
            S_EVAL_S: begin
               if (i_done_evaluate && !start_eval_q) begin
                  sr_q        <= i_evaluate_out;
                  start_add_q <= 1'b1;
                  state_q     <= S_ADD_B;
               end
            end
            S_ADD_B: begin
               if (i_done_add32 && !start_add_q) begin
                  beta_q  <= i_add_out_add32;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_q_addr     = '0;
      o_q_rd       = 1'b0;
      o_s_addr     = '0;
      o_s_rd       = 1'b0;
      o_q_s        = 8'd0;
      o_r_eps      = '0;
      o_x_mul32    = 32'd0;
      o_y_mul32    = 32'd0;
      o_in_1_add32 = '0;
      o_in_2_add32 = '0;
      case (state_q)
         S_EVAL_Q: begin
            o_q_addr = i_q_s_addr;
            o_q_rd   = i_q_s_rd;
            o_q_s    = i_q;
            o_r_eps  = w_r;
         end
         S_EVAL_S: begin
            o_s_addr = i_q_s_addr;
            o_s_rd   = i_q_s_rd;
            o_q_s    = i_s;
            o_r_eps  = w_r;
         end
         S_MUL: begin
            o_x_mul32 = w_eps_lane[idx_q];
            o_y_mul32 = w_qr_lane[idx_q];
         end
         S_ADD_A: begin
            o_in_1_add32 = w_prod;
            o_in_2_add32 = w_a;
         end
         S_ADD_B: begin
            o_in_1_add32 = sr_q;
            o_in_2_add32 = w_b;
         end
         default: ;
      endcase
   end

   assign o_start_evaluate = start_eval_q;
   assign o_start_mul32    = start_mul_q;
   assign o_start_add32    = start_add_q;
   assign o_done           = done_q;
   assign o_alpha          = alpha_q;
   assign o_beta           = beta_q;

endmodule

`default_nettype wire

// File: tb/tb_compute_plain_broadcast.sv
// +----------------------------------------------------------------------------+
// | tb_compute_plain_broadcast: directed bench with evaluate/mul32/add32 stubs |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_compute_plain_broadcast;

   localparam int c_W  = 96;
   localparam int c_AW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [7:0]      q_byte = 8'd0;
   logic [7:0]      s_byte = 8'd0;
   logic [c_W-1:0]  a = '0, b = '0, r = '0, eps = '0;
   logic [c_AW-1:0] q_s_addr = '0;
   logic            q_s_rd = 1'b0;
   logic [c_W-1:0]  eval_out = '0;
   logic            done_eval = 1'b0;
   logic [31:0]     mul_out = '0;
   logic            done_mul = 1'b0;
   logic [c_W-1:0]  add_out = '0;
   logic            done_add = 1'b0;

   logic            o_done, o_q_rd, o_s_rd, o_start_evaluate, o_start_mul32, o_start_add32;
   logic [c_AW-1:0] o_q_addr, o_s_addr;
   logic [c_W-1:0]  o_alpha, o_beta, o_r_eps, o_in_1_add32, o_in_2_add32;
   logic [7:0]      o_q_s;
   logic [31:0]     o_x_mul32, o_y_mul32;

   compute_plain_broadcast dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .o_done(o_done),
      .i_q(q_byte), .o_q_addr(o_q_addr), .o_q_rd(o_q_rd),
      .i_s(s_byte), .o_s_addr(o_s_addr), .o_s_rd(o_s_rd),
      .i_a(a), .i_b(b), .i_r(r), .i_eps(eps),
      .o_alpha(o_alpha), .o_beta(o_beta),
      .o_start_evaluate(o_start_evaluate), .o_q_s(o_q_s),
      .i_q_s_addr(q_s_addr), .i_q_s_rd(q_s_rd), .o_r_eps(o_r_eps),
      .i_evaluate_out(eval_out), .i_done_evaluate(done_eval),
      .o_start_mul32(o_start_mul32), .o_x_mul32(o_x_mul32), .o_y_mul32(o_y_mul32),
      .i_o_mul32(mul_out), .i_done_mul32(done_mul),
      .o_start_add32(o_start_add32), .o_in_1_add32(o_in_1_add32),
      .o_in_2_add32(o_in_2_add32), .i_add_out_add32(add_out), .i_done_add32(done_add)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] gf8(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'd0;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ t;
         t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
      end
      return p;
   endfunction

   function automatic logic [31:0] gfmul32(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] z;
      for (int i = 0; i < 4; i++) z[8*i +: 8] = gf8(x[8*i +: 8], y[8*i +: 8]);
      return z;
   endfunction

   // Zero-filled Q/S memories with one cycle read latency.
   logic [7:0] q_mem [256];
   logic [7:0] s_mem [256];
   initial for (int i = 0; i < 256; i++) begin q_mem[i] = 8'd0; s_mem[i] = 8'd0; end
   always @(posedge clk) begin
      if (o_q_rd) q_byte <= q_mem[o_q_addr];
      if (o_s_rd) s_byte <= s_mem[o_s_addr];
   end

   // Evaluate stub: fixed 5/7 lanes, or memory mode folding read bytes.
   bit       mem_mode = 1'b0;
   int       ev_cnt = 0;
   bit       ev_phase_s = 1'b0;
   logic [7:0] ev_acc = 8'd0;
   always @(posedge clk) begin
      if (rst) begin
         ev_cnt <= 0; ev_phase_s <= 1'b0; done_eval <= 1'b0; q_s_rd <= 1'b0; ev_acc <= 8'd0;
      end else begin
         done_eval <= 1'b0;
         if (o_start_evaluate) begin
            ev_cnt <= 20;
            ev_acc <= 8'd0;
         end else if (ev_cnt > 0) begin
            ev_cnt <= ev_cnt - 1;
            ev_acc <= ev_acc ^ o_q_s;
            if (ev_cnt == 1) begin
               done_eval  <= 1'b1;
               ev_phase_s <= !ev_phase_s;
               if (mem_mode) eval_out <= {3{24'd0, ev_acc ^ o_q_s}};
               else          eval_out <= ev_phase_s ? {3{32'h7}} : {3{32'h5}};
            end
         end
         q_s_rd   <= (ev_cnt > 1);
         q_s_addr <= 8'(ev_cnt);
      end
   end

   always @(posedge clk) begin
      done_mul <= o_start_mul32;
      if (o_start_mul32) mul_out <= gfmul32(o_x_mul32, o_y_mul32);
      done_add <= o_start_add32;
      if (o_start_add32) add_out <= o_in_1_add32 ^ o_in_2_add32;
   end

   int   done_cnt = 0, pulse_viol = 0, overlap_viol = 0, q_rd_seen = 0, s_rd_seen = 0;
   logic prev_se = 1'b0, prev_sm = 1'b0, prev_sa = 1'b0, prev_dn = 1'b0;
   always @(negedge clk) begin
      if (o_done) done_cnt++;
      if ((o_start_evaluate && prev_se) || (o_start_mul32 && prev_sm) ||
          (o_start_add32 && prev_sa) || (o_done && prev_dn)) pulse_viol++;
      if (o_q_rd && o_s_rd) overlap_viol++;
      if (o_q_rd) q_rd_seen++;
      if (o_s_rd) s_rd_seen++;
      prev_se = o_start_evaluate; prev_sm = o_start_mul32;
      prev_sa = o_start_add32;    prev_dn = o_done;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic run(input string tag, input int restart_at, output int cyc);
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (cyc == restart_at) start = 1'b1;
         if (cyc == restart_at + 1) start = 1'b0;
      end while (!o_done && cyc < 400);
      chk({tag, "_done_seen"}, o_done, 1'b1);
   endtask

   int cyc;
   int done_before;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_done", o_done, 1'b0);
      chk("rst_alpha", o_alpha, '0);
      chk("rst_beta", o_beta, '0);
      chk("rst_q_rd", o_q_rd, 1'b0);
      chk("rst_s_rd", o_s_rd, 1'b0);
      chk("rst_start_eval", o_start_evaluate, 1'b0);
      chk("rst_start_mul", o_start_mul32, 1'b0);
      chk("rst_start_add", o_start_add32, 1'b0);
      rst = 1'b0;

      // Zero Q/S memories through the memory-reading evaluate.
      mem_mode = 1'b1;
      r = {3{32'h12}}; eps = {3{32'h9}}; a = {3{32'h1}}; b = {3{32'h1}};
      done_before = done_cnt;
      run("mem", -5, cyc);
      chk("mem_alpha", o_alpha, {3{32'h1}});
      chk("mem_beta", o_beta, {3{32'h1}});
      @(negedge clk);
      chk("mem_done_one_cycle", o_done, 1'b0);
      chk("mem_done_count", 32'(done_cnt - done_before), 32'd1);
      chk("mem_q_read_seen", q_rd_seen > 0, 1'b1);
      chk("mem_s_read_seen", s_rd_seen > 0, 1'b1);

      // Stub evaluate, per-lane eps.
      mem_mode = 1'b0;
      eps = {32'h1, 32'h2, 32'h3}; a = '0; b = '0;
      run("stub", -5, cyc);
      $display("run latency: %0d cycles", cyc);
      chk("stub_alpha", o_alpha, {32'h5, 32'hA, 32'hF});
      chk("stub_beta", o_beta, {3{32'h7}});
      chk("stub_latency_bound", cyc <= 59, 1'b1);
      @(negedge clk);
      chk("stub_done_one_cycle", o_done, 1'b0);

      // Restart attempt mid-run.
      eps = {32'h2, 32'h1, 32'h4}; a = {3{32'h10}}; b = {3{32'h10}};
      done_before = done_cnt;
      run("restart", 10, cyc);
      chk("restart_alpha", o_alpha, {32'h1A, 32'h15, 32'h04});
      chk("restart_beta", o_beta, {3{32'h17}});
      repeat (60) @(negedge clk);
      chk("restart_done_count", 32'(done_cnt - done_before), 32'd1);

      // Reset while multiplying.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!o_start_mul32 && cyc < 100) begin @(negedge clk); cyc++; end
      chk("reached_mul", o_start_mul32, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_alpha", o_alpha, '0);
      chk("midrst_beta", o_beta, '0);
      chk("midrst_done", o_done, 1'b0);
      chk("midrst_start_mul", o_start_mul32, 1'b0);
      chk("midrst_mul_x", o_x_mul32, 32'd0);
      rst = 1'b0;
      done_before = done_cnt;
      repeat (60) @(negedge clk);
      chk("midrst_no_done", 32'(done_cnt - done_before), 32'd0);
      eps = {3{32'h3}}; a = '0; b = '0;
      run("post_rst", -5, cyc);
      chk("post_rst_alpha", o_alpha, {3{32'hF}});
      chk("post_rst_beta", o_beta, {3{32'h7}});

`ifdef CPB_INPUT_LATCH_EN
      eps = {3{32'h1}}; a = {3{32'h20}}; b = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      a = {3{32'hFF}};
      cyc = 0;
      while (!o_done && cyc < 400) begin @(negedge clk); cyc++; end
      chk("latch_done_seen", o_done, 1'b1);
      chk("latch_alpha", o_alpha, {3{32'h25}});
`endif

      @(negedge clk);
      chk("start_pulse_width", 32'(pulse_viol), 32'd0);
      chk("q_s_rd_overlap", 32'(overlap_viol), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
